// File: rtl/nibble_pkg.sv
// nibble_pkg: shared nibble width, 2-entry FIFO state encoding and word-width helper.
`default_nettype none

package nibble_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

  function automatic int word_w(input int nib_w, input int nibs);
    return nib_w * nibs;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_fifo2.sv
// nibble_fifo2: 2-entry valid/ready FIFO; reports occupancy and flags pushes that arrive while full.
`default_nettype none

module nibble_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic [1:0]   fill_o,
  output logic         drop_o
);
  import nibble_pkg::*;

  fifo_state_e  state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         pop;

  assign valid_o = (state_q != FIFO_EMPTY);
  assign fill_o  = state_q;
  assign data_o  = head_q;
  assign pop     = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    drop_o  = 1'b0;
    unique case (state_q)
      FIFO_EMPTY: begin
        if (push_i) begin
          head_d  = data_i;
          state_d = FIFO_ONE;
        end
      end
      FIFO_ONE: begin
        if (push_i && !pop) begin
          tail_d  = data_i;
          state_d = FIFO_FULL;
        end else if (!push_i && pop) begin
          state_d = FIFO_EMPTY;
        end else if (push_i && pop) begin
          head_d = data_i;
        end
      end
      FIFO_FULL: begin
        if (pop) begin
          head_d = tail_q;
          if (push_i) tail_d = data_i;
          else        state_d = FIFO_ONE;
        end else if (push_i) begin
          drop_o = 1'b1;
        end
      end
      default: state_d = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FIFO_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/nibble_packer.sv
// nibble_packer: aligns sin_valid to the shift-register output and packs NIBS nibbles per word.
// Define NIBBLE_PACKER_PARITY_EN to add out_par, the XOR reduction of each word carried through the FIFO.
`default_nettype none

module nibble_packer #(
  parameter int NIB_W = nibble_pkg::NIB_W,
  parameter int NIBS  = 4,
  parameter int LAT   = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      sin_valid,
  input  logic [NIB_W-1:0]                          nib_in,
  input  logic                                      flush,
  input  logic                                      clr_ovf,
  output logic [nibble_pkg::word_w(NIB_W,NIBS)-1:0] out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      ovf,
  output logic [1:0]                                fill
`ifdef NIBBLE_PACKER_PARITY_EN
  ,
  output logic                                      out_par
`endif
);
  import nibble_pkg::*;

  localparam int WORD_W = word_w(NIB_W, NIBS);
  localparam int CNT_W  = $clog2(NIBS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBS - 1);
`ifdef NIBBLE_PACKER_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FIFO_W = WORD_W + PAR_W;

  logic [LAT-1:0]    vpipe_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] word;
  logic              ovf_q, ovf_d;
  logic              nib_ok;
  logic              push;
  logic              drop;
  logic [FIFO_W-1:0] fifo_din;
  logic [FIFO_W-1:0] fifo_dout;

  assign nib_ok = vpipe_q[LAT-1];

  // word is the accumulator with the current nibble merged in, so a completing
  // nibble is pushed in the same cycle it arrives.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    push  = 1'b0;
    word  = acc_q;
    word[cnt_q*NIB_W +: NIB_W] = nib_in;
    if (flush) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (nib_ok) begin
      acc_d = word;
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
        push  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vpipe_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      vpipe_q[0] <= sin_valid;
      for (int i = 1; i < LAT; i++) vpipe_q[i] <= vpipe_q[i-1];
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef NIBBLE_PACKER_PARITY_EN
  assign fifo_din = {^word, word};
  assign out_par  = fifo_dout[WORD_W];
`else
  assign fifo_din = word;
`endif

  nibble_fifo2 #(
    .W(FIFO_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .push_i (push),
    .data_i (fifo_din),
    .ready_i(out_ready),
    .data_o (fifo_dout),
    .valid_o(out_valid),
    .fill_o (fill),
    .drop_o (drop)
  );

  assign out_data = fifo_dout[WORD_W-1:0];
  assign ovf      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: directed vectors through a modelled 4-stage shift register into nibble_packer.
`default_nettype none

module tb_nibble_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sin_valid = 1'b0;
  logic [3:0]  sin = 4'h0;
  logic [3:0]  nib_in;
  logic        flush = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        ovf;
  logic [1:0]  fill;
`ifdef NIBBLE_PACKER_PARITY_EN
  logic        out_par;
`endif

  logic [15:0] sr = 16'h0;
  int          nerr = 0;
  int          nchk = 0;

  always #5 clk = ~clk;

  // upstream 4-stage nibble shift register: sin -> sout after 4 clocks
  always @(posedge clk) sr <= {sr[11:0], sin};
  assign nib_in = sr[15:12];

  nibble_packer #(.NIB_W(4), .NIBS(4), .LAT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .sin_valid(sin_valid),
    .nib_in   (nib_in),
    .flush    (flush),
    .clr_ovf  (clr_ovf),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf      (ovf),
    .fill     (fill)
`ifdef NIBBLE_PACKER_PARITY_EN
    ,
    .out_par  (out_par)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] n);
    sin = n;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 4; i++) send(w[i*4 +: 4]);
  endtask

  // returns one cycle after the completed word lands in the FIFO
  task automatic send_word_settle(input logic [15:0] w);
    send_word(w);
    repeat (4) tick();
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_w;

    // 1: reset state
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_fill",  32'(fill),      32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    reset = 1'b1;
    repeat (8) tick();
    chk("idle_valid", 32'(out_valid), 32'd0);

    // 2: 1,2,3,4 -> 4321 exactly 5 cycles after the last sin_valid
    out_ready = 1'b1;
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    repeat (3) tick();
    chk("t2_early_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data",  32'(out_data),  32'h4321);
`ifdef NIBBLE_PACKER_PARITY_EN
    exp_w = 16'h4321;
    chk("t2_par", 32'(out_par), 32'(^exp_w));
`endif
    tick();
    chk("t2_popped", 32'(out_valid), 32'd0);

    // 3: gaps do not advance the count
    send(4'hA); send(4'hB);
    repeat (3) tick();
    chk("t3_gap_valid", 32'(out_valid), 32'd0);
    send(4'hC); send(4'hD);
    repeat (3) tick();
    chk("t3_early_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_data",  32'(out_data),  32'hDCBA);
    tick();

    // 4: backpressure, overflow drop, drain order, clr_ovf
    out_ready = 1'b0;
    send_word_settle(16'h1357);
    chk("t4_fill1", 32'(fill), 32'd1);
    send_word_settle(16'h2468);
    chk("t4_fill2", 32'(fill), 32'd2);
    chk("t4_ovf0",  32'(ovf),  32'd0);
    send_word_settle(16'h9ABC);
    chk("t4_fill3", 32'(fill), 32'd2);
    chk("t4_ovf1",  32'(ovf),  32'd1);
    chk("t4_head1", 32'(out_data), 32'h1357);
    pop_one();
    chk("t4_head2", 32'(out_data), 32'h2468);
    chk("t4_fill_d1", 32'(fill), 32'd1);
    pop_one();
    chk("t4_empty", 32'(out_valid), 32'd0);
    chk("t4_ovf_sticky", 32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t4_ovf_clr", 32'(ovf), 32'd0);

    // 5: push coinciding with pop while FULL
    send_word_settle(16'h1111);
    send_word_settle(16'h2222);
    chk("t5_full", 32'(fill), 32'd2);
    send_word(16'h3333);
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_fill", 32'(fill), 32'd2);
    chk("t5_ovf",  32'(ovf),  32'd0);
    chk("t5_head", 32'(out_data), 32'h2222);
    pop_one();
    chk("t5_head2", 32'(out_data), 32'h3333);
    pop_one();
    chk("t5_empty", 32'(fill), 32'd0);

    // 6: flush discards the partial word
    out_ready = 1'b1;
    send(4'h5); send(4'h6);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    send(4'h7); send(4'h8); send(4'h9); send(4'hA);
    chk("t6_no_stale", 32'(out_valid), 32'd0);
    repeat (3) tick();
    chk("t6_early_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t6_valid", 32'(out_valid), 32'd1);
    chk("t6_data",  32'(out_data),  32'hA987);
    tick();

    // 1b: asynchronous reset mid-stream with FIFO full and ovf set
    out_ready = 1'b0;
    send_word_settle(16'h5555);
    send_word_settle(16'h6666);
    send_word_settle(16'h7777);
    chk("r_pre_ovf", 32'(ovf), 32'd1);
    send(4'hE); send(4'hF);
    #2;
    reset = 1'b0;
    #1;
    chk("r_valid", 32'(out_valid), 32'd0);
    chk("r_data",  32'(out_data),  32'd0);
    chk("r_fill",  32'(fill),      32'd0);
    chk("r_ovf",   32'(ovf),       32'd0);
    #3;
    reset = 1'b1;
    repeat (10) tick();
    chk("r_idle_valid", 32'(out_valid), 32'd0);
    chk("r_idle_ovf",   32'(ovf),       32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
